extend_unit: RTL and testbench

EXTEND_UNIT -- requirements
Module: extend_unit

---
 rtl/extend_unit.sv | 120 ++++++++++++
 tb/tb_extend_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/extend_unit.sv
// Sign/zero extension unit with lane selection, behind a two-entry elastic buffer.
// Results leave one cycle after acceptance and in acceptance order.
module extend_unit #(
    parameter  int unsigned INSIZE  = 16,
    parameter  int unsigned OUTSIZE = 32,
    localparam int unsigned LANEW   = (INSIZE / 8 > 2) ? $clog2(INSIZE / 8) : 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSIZE-1:0]  in_data,
    input  logic [2:0]         mode,
    input  logic [LANEW-1:0]   sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUTSIZE-1:0] out_data,
    output logic               out_err
);

    localparam int unsigned EXTW   = OUTSIZE - INSIZE;
    localparam int unsigned HALVES = INSIZE / 16;

    logic [LANEW-1:0]   hsel;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [OUTSIZE-1:0] res_data_c;
    logic               res_err_c;

    logic               skid_valid;
    logic [OUTSIZE-1:0] skid_data;
    logic               skid_err;

    logic               out_valid_n, skid_valid_n, out_err_n, skid_err_n;
    logic [OUTSIZE-1:0] out_data_n, skid_data_n;
    logic               accept, load_out;

    // Extension result for the beat currently offered.
    always_comb begin
        hsel       = sel >> 1;
        lane_b     = 8'(in_data >> {sel, 3'b000});
        lane_h     = 16'(in_data >> {hsel, 4'b0000});
        res_data_c = '0;
        res_err_c  = 1'b0;
        case (mode)
            3'b000: res_data_c = OUTSIZE'($signed(in_data));
            3'b001: res_data_c = OUTSIZE'(in_data);
            3'b010: res_data_c = {in_data, {EXTW{1'b0}}};
            3'b011: res_data_c = OUTSIZE'($signed(lane_b));
            3'b100: res_data_c = OUTSIZE'(lane_b);
            3'b101, 3'b110: begin
                // A half lane beyond the field is treated like the reserved mode.
                if (32'(hsel) >= HALVES) begin
                    res_err_c = 1'b1;
                end else if (mode == 3'b101) begin
                    res_data_c = OUTSIZE'($signed(lane_h));
                end else begin
                    res_data_c = OUTSIZE'(lane_h);
                end
            end
            default: res_err_c = 1'b1;
        endcase
    end

    assign accept   = in_valid & in_ready;
    assign load_out = ~out_valid | out_ready;

    // Next state of the output and skid registers.
    always_comb begin
        out_valid_n  = out_valid;
        out_data_n   = out_data;
        out_err_n    = out_err;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_err_n   = skid_err;
        if (load_out) begin
            if (skid_valid) begin
                out_valid_n  = 1'b1;
                out_data_n   = skid_data;
                out_err_n    = skid_err;
                skid_valid_n = 1'b0;
                skid_data_n  = '0;
                skid_err_n   = 1'b0;
            end else if (accept) begin
                out_valid_n = 1'b1;
                out_data_n  = res_data_c;
                out_err_n   = res_err_c;
            end else begin
                out_valid_n = 1'b0;
                out_data_n  = '0;
                out_err_n   = 1'b0;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_data_n  = res_data_c;
            skid_err_n   = res_err_c;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            out_err    <= out_err_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            skid_err   <= skid_err_n;
            in_ready   <= ~skid_valid_n;
        end
    end

endmodule

// File: tb/tb_extend_unit.sv
// Bench for extend_unit (INSIZE=16, OUTSIZE=32): directed scenarios plus random
// traffic scored against an arithmetic reference model.
module tb_extend_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_data;
    logic [2:0]  mode;
    logic        sel;
    logic [31:0] out_data;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          drain_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic        hold_pend = 1'b0;
    logic [32:0] hold_val;

    extend_unit #(.INSIZE(16), .OUTSIZE(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mode(mode), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else pass_cnt++;
    endtask

    // {err, data} expected for one beat, from integer arithmetic on the lane value.
    function automatic logic [32:0] ref_ext(input logic [15:0] d, input logic [2:0] m, input logic s);
        int unsigned du, b;
        int          v;
        du = 32'(d);
        b  = (du >> (8 * int'(s))) % 256;
        case (m)
            3'd0, 3'd5: begin v = (du >= 32768) ? int'(du) - 65536 : int'(du); return {1'b0, 32'(v)}; end
            3'd1, 3'd6: return {1'b0, du};
            3'd2:       return {1'b0, du * 65536};
            3'd3:       begin v = (b >= 128) ? int'(b) - 256 : int'(b); return {1'b0, 32'(v)}; end
            3'd4:       return {1'b0, b};
            default:    return {1'b1, 32'd0};
        endcase
    endfunction

    // Scoreboard: drains pop first (an accept this edge cannot be drained this edge).
    always @(posedge CLK) begin
        if (RESET) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'({out_err, out_data}), 64'(hold_val));
            end
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_err, out_data};
            if (!out_valid) check("idle_zero", 64'({out_err, out_data}), 64'(0));
            if (out_valid && out_ready) begin
                drain_cnt++;
                check("queue_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e[31:0]));
                    check("out_err", 64'(out_err), 64'(e[32]));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_ext(in_data, mode, sel));
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [2:0] m, input logic s,
                            input logic [15:0] d, input logic [32:0] exp);
        in_valid = 1'b1; mode = m; sel = s; in_data = d; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_result"}, 64'({out_err, out_data}), 64'(exp));
    endtask

    initial begin
        RESET = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_data = 16'hFFFF; mode = 3'd0; sel = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'({out_err, out_data}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        step(); step();
        check("rst_ignores_in", 64'(out_valid), 64'(0));
        in_valid = 1'b0;
        RESET = 1'b0;

        // V1 / V2 / V4: single beats with the consumer always ready
        send_one("v1_sext", 3'd0, 1'b0, 16'h8001, {1'b0, 32'hFFFF8001});
        send_one("v1_zext", 3'd1, 1'b0, 16'h8001, {1'b0, 32'h00008001});
        send_one("v2_upper", 3'd2, 1'b0, 16'h1234, {1'b0, 32'h12340000});
        send_one("v2_sbyte", 3'd3, 1'b1, 16'h807F, {1'b0, 32'hFFFFFF80});
        send_one("v2_zbyte", 3'd4, 1'b0, 16'h807F, {1'b0, 32'h0000007F});
        send_one("v2_shalf", 3'd5, 1'b1, 16'hC003, {1'b0, 32'hFFFFC003});
        send_one("v2_zhalf", 3'd6, 1'b0, 16'hC003, {1'b0, 32'h0000C003});
        send_one("v4_reserved", 3'd7, 1'b1, 16'hABCD, {1'b1, 32'h0});
        send_one("v4_after", 3'd0, 1'b0, 16'h0005, {1'b0, 32'h5});
        step();
        check("v1_empty_after", 64'(out_valid), 64'(0));

        // V3: backpressure fills output and skid, then drains without bubbles
        out_ready = 1'b0; in_valid = 1'b1; mode = 3'd0; sel = 1'b0; in_data = 16'h0001;
        step();
        check("v3_ready_a", 64'(in_ready), 64'(1));
        in_data = 16'h0002;
        step();
        check("v3_ready_low", 64'(in_ready), 64'(0));
        in_data = 16'h0003;
        step();
        check("v3_still_low", 64'(in_ready), 64'(0));
        check("v3_hold_a", 64'(out_data), 64'(32'h1));
        out_ready = 1'b1;
        step();
        check("v3_out_b", 64'({out_valid, out_data}), 64'({1'b1, 32'h2}));
        check("v3_ready_back", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        check("v3_out_c", 64'({out_valid, out_data}), 64'({1'b1, 32'h3}));
        step();
        check("v3_empty", 64'(out_valid), 64'(0));

        // V5: asynchronous reset with both entries full
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
        step();
        in_data = 16'h0022;
        step();
        in_valid = 1'b0;
        check("v5_full", 64'(in_ready), 64'(0));
        #2;
        RESET = 1'b1;
        exp_q.delete();
        #1;
        check("v5_async_valid", 64'(out_valid), 64'(0));
        check("v5_async_ready", 64'(in_ready), 64'(1));
        check("v5_async_data", 64'(out_data), 64'(0));
        in_valid = 1'b1;
        step();
        RESET = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        check("v5_no_stale", 64'(out_valid), 64'(0));

        // V6: 16 back-to-back random beats at full throughput
        drain_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            mode = 3'($urandom_range(0, 6));
            sel = 1'($urandom_range(0, 1));
            in_data = 16'($urandom);
            step();
            check("v6_in_ready", 64'(in_ready), 64'(1));
            check("v6_out_valid", 64'(out_valid), 64'(1));
        end
        in_valid = 1'b0;
        step();
        check("v6_drains", 64'(drain_cnt), 64'(16));
        check("v6_empty", 64'(out_valid), 64'(0));

        // Random traffic with random backpressure, all modes
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            mode = 3'($urandom_range(0, 7));
            sel = 1'($urandom_range(0, 1));
            in_data = 16'($urandom);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        check("final_idle", 64'(out_valid), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
